jcs_gate_exerciser: RTL

//  Self-test sequencer for the jcsbasic gate demo. On START it locks the selected demo mode and walks every

---
 rtl/jcs_gate_exerciser_pkg.sv | 57 +++++
 rtl/jcs_gate_exerciser_golden.sv | 29 ++
 rtl/jcs_gate_exerciser.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/jcs_gate_exerciser_pkg.sv
// Shared definitions for the jcsbasic gate exerciser: demo mode codes,
// sequencer states and helpers that give the size of each mode's vector space.
package jcs_gate_exerciser_pkg;

  // Demo mode codes as presented on the mode selector.
  typedef enum logic [3:0] {
    MODE_BUF    = 4'd0,
    MODE_NOT    = 4'd1,
    MODE_NAND   = 4'd2,
    MODE_AND    = 4'd3,
    MODE_OR     = 4'd4,
    MODE_XOR    = 4'd5,
    MODE_DEC3   = 4'd6,
    MODE_ENABLE = 4'd7,
    MODE_BUS1   = 4'd8
  } mode_t;

  // Highest mode code that has a gate behind it; anything above is rejected.
  localparam logic [3:0] MODE_LAST = 4'd8;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DWELL  = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  // True when the mode code selects an existing gate.
  function automatic logic mode_valid(input logic [3:0] mode);
    return (mode <= MODE_LAST);
  endfunction

  // Number of gate input bits exercised in a mode (0 for unknown codes).
  function automatic logic [3:0] mode_width(input logic [3:0] mode);
    logic [3:0] w;
    w = 4'd0;
    case (mode)
      MODE_BUF, MODE_NOT:                      w = 4'd1;
      MODE_NAND, MODE_AND, MODE_OR, MODE_XOR:  w = 4'd2;
      MODE_DEC3:                               w = 4'd3;
      MODE_ENABLE, MODE_BUS1:                  w = 4'd9;
      default:                                 w = 4'd0;
    endcase
    return w;
  endfunction

  // Index of the final vector of a mode, i.e. 2^W-1 (0 for unknown codes).
  function automatic logic [8:0] mode_last_vec(input logic [3:0] mode);
    logic [9:0] span;
    span = 10'd1 << mode_width(mode);
    return 9'(span - 10'd1);
  endfunction

endpackage

// File: rtl/jcs_gate_exerciser_golden.sv
// Golden reference for every jcsbasic demo gate: given the demo mode and the
// stimulus word, produce the LED[7:0] pattern a healthy board shows.
// Purely combinational so the sequencer can compare in the same cycle.
module jcs_golden
  import jcs_gate_exerciser_pkg::*;
(
  input  logic [3:0] mode,
  input  logic [8:0] stim,
  output logic [7:0] exp_resp
);

  // Select the expected LED pattern for the active gate; unknown modes read 0.
  always_comb begin
    exp_resp = 8'h00;
    case (mode)
      MODE_BUF:    exp_resp = {7'b0, stim[0]};
      MODE_NOT:    exp_resp = {7'b0, ~stim[0]};
      MODE_NAND:   exp_resp = {7'b0, ~(stim[1] & stim[0])};
      MODE_AND:    exp_resp = {7'b0, stim[1] & stim[0]};
      MODE_OR:     exp_resp = {7'b0, stim[1] | stim[0]};
      MODE_XOR:    exp_resp = {7'b0, stim[1] ^ stim[0]};
      MODE_DEC3:   exp_resp = 8'b1 << stim[2:0];
      MODE_ENABLE: exp_resp = stim[8] ? stim[7:0] : 8'h00;
      MODE_BUS1:   exp_resp = stim[8] ? {stim[7:1], 1'b1} : stim[7:0];
      default:     exp_resp = 8'h00;
    endcase
  end

endmodule

// File: rtl/jcs_gate_exerciser.sv
// Self-test sequencer for the jcsbasic gate demo. A START click locks the
// selected mode, then every input combination of that gate is driven on STIM,
// allowed to settle, and the muxed LED response is compared with the golden
// model. The run ends at the first mismatch or after the last vector; moving
// the mode selector mid-run abandons the run without a result.
module jcs_gate_exerciser
  import jcs_gate_exerciser_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned DWELL_CYCLES  = 25000000,
  parameter int unsigned CNT_W         = 25
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [3:0] MODE,
  input  logic       START,
  input  logic [7:0] RESP,
  output logic [8:0] STIM,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [8:0] ERR_VEC,
  output logic [7:0] ERR_GOT
);

  // Counter reload values: the counter runs down to zero inclusive, so a
  // load of N-1 gives N cycles in the state.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  =
    (DWELL_CYCLES == 0) ? '0 : CNT_W'(DWELL_CYCLES - 1);

  state_t           state;
  logic [3:0]       lmode;
  logic [8:0]       vec;
  logic [CNT_W-1:0] cnt;

  logic [7:0]       exp_resp;
  logic [8:0]       last_vec;
  logic             resp_ok;
  logic             vec_is_last;
  logic             cnt_zero;

  // Golden response for the locked mode and the vector currently applied.
  jcs_golden u_golden (
    .mode     (lmode),
    .stim     (vec),
    .exp_resp (exp_resp)
  );

  // Derive compare and end-of-walk conditions for the sequencer.
  always_comb begin
    last_vec    = mode_last_vec(lmode);
    resp_ok     = (RESP == exp_resp);
    vec_is_last = (vec == last_vec);
    cnt_zero    = (cnt == '0);
  end

  // Sequencer: run control, vector walk, settle/dwell timing and result capture.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state   <= ST_IDLE;
      lmode   <= 4'd0;
      vec     <= 9'd0;
      cnt     <= '0;
      STIM    <= 9'd0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      PASS    <= 1'b0;
      ERR_VEC <= 9'd0;
      ERR_GOT <= 8'h00;
    end else if (state == ST_IDLE || state == ST_FIN) begin
      if (START) begin
        lmode   <= MODE;
        vec     <= 9'd0;
        cnt     <= '0;
        PASS    <= 1'b0;
        ERR_VEC <= 9'd0;
        ERR_GOT <= 8'h00;
        if (mode_valid(MODE)) begin
          BUSY  <= 1'b1;
          DONE  <= 1'b0;
          state <= ST_APPLY;
        end else begin
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          state <= ST_FIN;
        end
      end
    end else if (MODE != lmode) begin
      state <= ST_IDLE;
      vec   <= 9'd0;
      cnt   <= '0;
      STIM  <= 9'd0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      PASS  <= 1'b0;
    end else begin
      case (state)
        ST_APPLY: begin
          STIM  <= vec;
          cnt   <= SETTLE_LOAD;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            state <= ST_CHECK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (!resp_ok) begin
            ERR_VEC <= vec;
            ERR_GOT <= RESP;
            PASS    <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            state   <= ST_FIN;
          end else if (vec_is_last) begin
            PASS  <= 1'b1;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= ST_FIN;
          end else if (DWELL_CYCLES == 0) begin
            vec   <= vec + 9'd1;
            state <= ST_APPLY;
          end else begin
            cnt   <= DWELL_LOAD;
            state <= ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (cnt_zero) begin
            vec   <= vec + 9'd1;
            state <= ST_APPLY;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
